seq_divider8: RTL and testbench
===============================

# seq_divider8

Sequential signed divider: the inverse of the 8x8 signed combinational multiplier. It takes a 16-bit signed dividend, the multiplier's product width, and an 8-bit signed divisor. It returns an 8-bit quotient and an 8-bit remainder, computed as one restoring step per clock. It sits beside the multiplier in the fundamental arithmetic library, for normalisation and scaling paths of the systolic array, and uses a start/done handshake.

## Interface
- W, 8, operand width; dividend is 2W bits wide, quotient and remainder are W bits wide.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- dividend  in  2W  signed dividend; captured on the accepting edge.
- divisor  in  W  signed divisor; captured on the accepting edge.
- busy  out  1  high while a division is in flight.
- done  out  1  one-cycle pulse: results are valid.
- quotient  out  W  signed quotient.
- remainder  out  W  signed remainder.
- div_by_zero  out  1  the divisor was 0.
- overflow  out  1  the true quotient is outside [-2^(W-1), 2^(W-1)-1].

## Operation
- States:
  - IDLE: waits for start.
  - CALC: 2W iterations; a counter runs 0..2W-1.
  - FIX: applies signs, checks range, registers outputs.
- Accept: in IDLE with start=1, the block:
  - latches |dividend| (2W-bit unsigned, so -32768 maps to 0x8000) and |divisor| (W+1 bits internally);
  - latches sign flags;
  - clears the partial remainder and the counter.
- Next state after accept:
  - divisor==0: goes straight to FIX.
  - otherwise: goes to CALC.
- CALC, each cycle, one restoring step:
  - shift the partial remainder left, bringing in the next dividend MSB;
  - if partial remainder >= |divisor|, subtract and shift a 1 into the quotient; else shift a 0;
  - after step 2W-1, go to FIX.
- FIX:
  - Quotient sign = sign(dividend) XOR sign(divisor); truncation is toward zero.
  - Remainder takes the sign of the dividend, so dividend = q*divisor + r.
  - Overflow: the 2W-bit signed quotient does not fit in W bits. Then quotient saturates to 0x7F (positive) or 0x80 (negative), remainder=0, overflow=1.
  - Divide by zero: quotient=0, remainder=0, div_by_zero=1, overflow=0.
  - Next state: IDLE.
- Outputs quotient, remainder, div_by_zero and overflow:
  - hold their values until the FIX of the next operation;
  - are not cleared on a new start.
- start while busy is ignored, with no queuing.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0; state returns to IDLE. This applies immediately on rst_n low, including mid-CALC: the operation is dropped and no done is issued.
- Call the accepting edge E0.
  - busy: rises after E0.
  - CALC: edges E1..E2W.
  - FIX: edge E2W+1 registers results, raises done for one cycle and drops busy.
  - Latency: 2W+1 edges (17 for W=8).
- Divide by zero: FIX at E1; done and results visible after E1.
- done and busy are never high together.
- Back-to-back: start held high during the done cycle is accepted, since state is already IDLE. The next done follows 2W+1 edges later.
- Inputs are only sampled at E0 and may change freely afterwards.

## Structure
- Shared package div_pkg holds:
  - the state encoding (IDLE, CALC, FIX);
  - W default;
  - saturation constants QMAX=0x7F, QMIN=0x80.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in seq_divider8.
- Sign/magnitude conversion and the FIX logic live inline in the top module.

## Test plan
- 42 / 7 → after 17 edges: done=1, quotient=6, remainder=0, overflow=0, div_by_zero=0.
- -100 / 7 → quotient=0xF2 (-14), remainder=0xFE (-2).
- 16384 / -128 → quotient=0x80 (-128), overflow=0.
- Saturation:
  - 16384 / 1 → quotient=0x7F, remainder=0, overflow=1.
  - -32768 / -128 → quotient=0x7F, overflow=1.
- 1234 / 0 → done after 1 edge, div_by_zero=1, quotient=0, remainder=0.
- Reset and round trip:
  - rst_n pulsed low at CALC cycle 5 → all outputs 0 immediately, no done.
  - A following 1000/10 then yields quotient=100.
- Multiplier cross-check: 2000 random (a,b), b≠0. Feed a*b from the multiplier as the dividend with divisor b → quotient=a, remainder=0. Issue each start in the done cycle to exercise back-to-back.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: operand width,
// FSM state encoding and quotient saturation constants.
package div_pkg;

    localparam int unsigned W = 8;

    localparam logic [W-1:0] QMAX = 8'h7F;
    localparam logic [W-1:0] QMIN = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
    import div_pkg::*;
(
    input  logic [W-1:0] rem_i,
    input  logic         dvd_bit_i,
    input  logic [W:0]   dsor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted;

    // Incoming remainder is always below |divisor| <= 2^(W-1), so the
    // shifted value fits in W+1 bits and any difference fits back in W.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        if (shifted >= dsor_i) begin
            rem_o   = W'(shifted - dsor_i);
            q_bit_o = 1'b1;
        end else begin
            rem_o   = W'(shifted);
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider8.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, one restoring
// step per clock, with start/done handshake, saturation and divide-by-zero.
module seq_divider8
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(2*W);
    localparam logic [2*W-1:0] MAG_NEG = (2*W)'(1) << (W-1);
    localparam logic [2*W-1:0] MAG_POS = MAG_NEG - (2*W)'(1);

    state_t          state_q, state_d;
    logic [2*W-1:0]  dvd_q, dvd_d;
    logic [W:0]      dsor_q, dsor_d;
    logic [W-1:0]    prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sdvd_q, sdvd_d;
    logic            sdsor_q, sdsor_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [2*W-1:0]  dvd_mag;
    logic [W:0]      dsor_sx;
    logic [W:0]      dsor_mag;
    logic [W-1:0]    step_rem;
    logic            step_qbit;
    logic            neg_q;
    logic            q_ovf;

    div_step u_step (
        .rem_i     (prem_q),
        .dvd_bit_i (dvd_q[2*W-1]),
        .dsor_i    (dsor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == CW'(2*W-1)) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == FIX);
    end

    // The dividend register doubles as the quotient register: MSBs shift
    // out into the step while quotient bits shift in at the LSB.
    always_comb begin
        dvd_mag  = dividend[2*W-1] ? ('0 - dividend) : dividend;
        dsor_sx  = {divisor[W-1], divisor};
        dsor_mag = divisor[W-1] ? ('0 - dsor_sx) : dsor_sx;
        neg_q    = sdvd_q ^ sdsor_q;
        q_ovf    = neg_q ? (dvd_q > MAG_NEG) : (dvd_q > MAG_POS);

        dvd_d   = dvd_q;
        dsor_d  = dsor_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        sdvd_d  = sdvd_q;
        sdsor_d = sdsor_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dvd_mag;
                    dsor_d  = dsor_mag;
                    prem_d  = '0;
                    cnt_d   = '0;
                    sdvd_d  = dividend[2*W-1];
                    sdsor_d = divisor[W-1];
                end
            end
            CALC: begin
                dvd_d  = {dvd_q[2*W-2:0], step_qbit};
                prem_d = step_rem;
                cnt_d  = cnt_q + CW'(1);
            end
            FIX: begin
                if (dsor_q == '0) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else if (q_ovf) begin
                    quot_d = neg_q ? QMIN : QMAX;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = neg_q ? ('0 - dvd_q[W-1:0]) : dvd_q[W-1:0];
                    rem_d  = sdvd_q ? ('0 - prem_q) : prem_q;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q   <= '0;
            dsor_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            sdvd_q  <= 1'b0;
            sdsor_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dvd_q   <= dvd_d;
            dsor_q  <= dsor_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            sdvd_q  <= sdvd_d;
            sdsor_q <= sdsor_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Scoreboard bench for seq_divider8: directed vectors, busy/reset behaviour
// and a multiplier round trip issued back-to-back in each done cycle.
module tb_seq_divider8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         dd;
        int         ds;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } vec_t;

    seq_divider8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports done.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_busy_excl", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    {24'd0, quotient},    {24'd0, e.q});
                chk("remainder",   {24'd0, remainder},   {24'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("overflow",    {31'd0, overflow},    {31'd0, e.ovf});
                chk("latency",     32'(cyc),             32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input int dd, input int ds, input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input bit track);
        int lat;
        lat      = (ds == 0) ? 1 : 17;
        start    = 1'b1;
        dividend = 16'(dd);
        divisor  = 8'(ds);
        if (track) sb.push_back('{q: eq, r: er, dbz: edbz, ovf: eovf, cyc: cyc + 1 + lat});
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 40);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
        end
    endtask

    vec_t vecs[13] = '{
        '{dd:     42, ds:    7, q: 8'h06, r: 8'h00, dbz: 1'b0, ovf: 1'b0},
        '{dd:   -100, ds:    7, q: 8'hF2, r: 8'hFE, dbz: 1'b0, ovf: 1'b0},
        '{dd:  16384, ds: -128, q: 8'h80, r: 8'h00, dbz: 1'b0, ovf: 1'b0},
        '{dd:  16384, ds:    1, q: 8'h7F, r: 8'h00, dbz: 1'b0, ovf: 1'b1},
        '{dd: -32768, ds: -128, q: 8'h7F, r: 8'h00, dbz: 1'b0, ovf: 1'b1},
        '{dd:   1234, ds:    0, q: 8'h00, r: 8'h00, dbz: 1'b1, ovf: 1'b0},
        '{dd: -32768, ds:    1, q: 8'h80, r: 8'h00, dbz: 1'b0, ovf: 1'b1},
        '{dd:  32767, ds: -128, q: 8'h80, r: 8'h00, dbz: 1'b0, ovf: 1'b1},
        '{dd:   -129, ds:   -1, q: 8'h7F, r: 8'h00, dbz: 1'b0, ovf: 1'b1},
        '{dd:   -128, ds:    1, q: 8'h80, r: 8'h00, dbz: 1'b0, ovf: 1'b0},
        '{dd:    127, ds:   -1, q: 8'h81, r: 8'h00, dbz: 1'b0, ovf: 1'b0},
        '{dd:      7, ds:   -2, q: 8'hFD, r: 8'h01, dbz: 1'b0, ovf: 1'b0},
        '{dd:     -7, ds:    2, q: 8'hFD, r: 8'hFF, dbz: 1'b0, ovf: 1'b0}
    };

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",      {31'd0, busy},        32'd0);
        chk("rst_done",      {31'd0, done},        32'd0);
        chk("rst_quotient",  {24'd0, quotient},    32'd0);
        chk("rst_remainder", {24'd0, remainder},   32'd0);
        chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
        chk("rst_ovf",       {31'd0, overflow},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].dd, vecs[i].ds, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, 1'b1);
            wait_done();
        end

        // A start pulse while busy must be ignored entirely.
        issue(42, 7, 8'h06, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd5;
        divisor  = 8'd0;
        @(negedge clk);
        start    = 1'b0;
        wait_done();
        @(negedge clk);

        // Asynchronous reset in the middle of CALC drops the operation.
        issue(1000, 10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",      {31'd0, busy},        32'd0);
        chk("midrst_done",      {31'd0, done},        32'd0);
        chk("midrst_quotient",  {24'd0, quotient},    32'd0);
        chk("midrst_remainder", {24'd0, remainder},   32'd0);
        chk("midrst_dbz",       {31'd0, div_by_zero}, 32'd0);
        chk("midrst_ovf",       {31'd0, overflow},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("postrst_idle", {31'd0, busy}, 32'd0);

        issue(1000, 10, 8'd100, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Multiplier round trip, each start issued in the preceding done cycle.
        for (int n = 0; n < 2000; n++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255)) - 128;
            do b = int'($urandom_range(0, 255)) - 128; while (b == 0);
            issue(a * b, b, 8'(a), 8'h00, 1'b0, 1'b0, 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
